// File: rtl/frame_capture_if.sv
// Pixel stream and classifier handshake between the capture sequencer and the
// hand-mask/classifier datapath.
interface frame_capture_if #(
    parameter int LENGTH     = 16,
    parameter int WIDTH      = 16,
    parameter int PIXEL_BITS = 24
);
    localparam int ROW_W = $clog2(LENGTH);
    localparam int COL_W = $clog2(WIDTH);

    logic                  pix_valid;
    logic [PIXEL_BITS-1:0] pix_hsv;
    logic [ROW_W-1:0]      pix_row;
    logic [COL_W-1:0]      pix_col;
    logic                  cls_start;
    logic                  cls_done;
    logic [1:0]            cls_result;

    modport master (
        output pix_valid, pix_hsv, pix_row, pix_col, cls_start,
        input  cls_done, cls_result
    );

    modport slave (
        input  pix_valid, pix_hsv, pix_row, pix_col, cls_start,
        output cls_done, cls_result
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Serial-to-pixel frame sequencer: assembles LSB-first HSV words from the Pi link,
// strobes them with row/column indices, runs the classifier and holds its result.
module frame_capture_ctrl #(
    parameter int LENGTH     = 16,
    parameter int WIDTH      = 16,
    parameter int PIXEL_BITS = 24,
    parameter int TIMEOUT    = 4096
) (
    input  logic                   slow_clk,
    input  logic                   dbnc_rst,
    input  logic                   dbnc_pi_clk,
    input  logic                   dbnc_bit,
    frame_capture_if.master        bus,
    output logic [1:0]             result,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   frame_err,
    output logic [2:0]             breadboard,
    output logic [5:0]             led
);

    localparam int ROW_W = $clog2(LENGTH);
    localparam int COL_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(PIXEL_BITS);
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PIXEL_BITS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LENGTH - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        WAIT_CLS = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic                  pi_prev_reg;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [ROW_W-1:0]      row_reg, row_next;
    logic [COL_W-1:0]      col_reg, col_next;
    logic [WD_W-1:0]       wdog_reg, wdog_next;
    logic [PIXEL_BITS-1:0] shift_reg, shift_next;
    logic                  pix_valid_reg, pix_valid_next;
    logic [PIXEL_BITS-1:0] pix_hsv_reg, pix_hsv_next;
    logic [ROW_W-1:0]      pix_row_reg, pix_row_next;
    logic [COL_W-1:0]      pix_col_reg, pix_col_next;
    logic                  cls_start_reg, cls_start_next;
    logic [1:0]            result_reg, result_next;
    logic                  result_valid_reg, result_valid_next;
    logic                  frame_err_reg, frame_err_next;
    logic [2:0]            bb_reg, bb_next;
    logic [3:0]            led_lo_reg, led_lo_next;

    logic                  pi_edge;
    logic                  word_done;
    logic                  wd_expired;
    logic                  accept_bit;
    logic [PIXEL_BITS-1:0] shift_upd;

    assign pi_edge    = dbnc_pi_clk & ~pi_prev_reg;
    assign word_done  = (bit_cnt_reg == LAST_BIT);
    assign wd_expired = (wdog_reg == WD_LAST);

    // Word as it stands once the bit arriving in this edge cycle is included.
    generate
        for (genvar gi = 0; gi < PIXEL_BITS; gi++) begin : g_shift
            assign shift_upd[gi] = (bit_cnt_reg == CNT_W'(gi)) ? dbnc_bit : shift_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next        = state_reg;
        bit_cnt_next      = bit_cnt_reg;
        row_next          = row_reg;
        col_next          = col_reg;
        wdog_next         = wdog_reg;
        shift_next        = shift_reg;
        pix_valid_next    = 1'b0;
        pix_hsv_next      = pix_hsv_reg;
        pix_row_next      = pix_row_reg;
        pix_col_next      = pix_col_reg;
        cls_start_next    = 1'b0;
        result_next       = result_reg;
        result_valid_next = result_valid_reg;
        frame_err_next    = frame_err_reg;
        bb_next           = bb_reg;
        led_lo_next       = led_lo_reg;
        accept_bit        = 1'b0;

        case (state_reg)
            IDLE: begin
                wdog_next = '0;
                if (pi_edge) begin
                    state_next = RECV;
                    accept_bit = 1'b1;
                end
            end

            RECV: begin
                // A stalled link drops the whole frame so the next one starts aligned.
                if (wd_expired) begin
                    state_next     = IDLE;
                    bit_cnt_next   = '0;
                    row_next       = '0;
                    col_next       = '0;
                    wdog_next      = '0;
                    frame_err_next = 1'b1;
                end else if (pi_edge) begin
                    wdog_next  = '0;
                    accept_bit = 1'b1;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end

            WAIT_CLS: begin
                if (pi_edge) begin
                    frame_err_next = 1'b1;
                end
                if (wd_expired) begin
                    state_next        = IDLE;
                    wdog_next         = '0;
                    frame_err_next    = 1'b1;
                    result_valid_next = 1'b0;
                    bb_next           = 3'b000;
                end else if (bus.cls_done && !cls_start_reg) begin
                    state_next        = IDLE;
                    wdog_next         = '0;
                    result_next       = bus.cls_result;
                    result_valid_next = 1'b1;
                    case (bus.cls_result)
                        2'b00: begin led_lo_next = 4'b0001; bb_next = 3'b110; end
                        2'b01: begin led_lo_next = 4'b0010; bb_next = 3'b101; end
                        2'b10: begin led_lo_next = 4'b0100; bb_next = 3'b011; end
                        default: begin led_lo_next = 4'b1000; bb_next = 3'b000; end
                    endcase
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase

        if (accept_bit) begin
            shift_next = shift_upd;
            if (word_done) begin
                bit_cnt_next   = '0;
                pix_valid_next = 1'b1;
                pix_hsv_next   = shift_upd;
                pix_row_next   = row_reg;
                pix_col_next   = col_reg;
                if (col_reg == LAST_COL) begin
                    col_next = '0;
                    if (row_reg == LAST_ROW) begin
                        row_next       = '0;
                        state_next     = WAIT_CLS;
                        cls_start_next = 1'b1;
                        wdog_next      = '0;
                    end else begin
                        row_next = row_reg + 1'b1;
                    end
                end else begin
                    col_next = col_reg + 1'b1;
                end
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge slow_clk or posedge dbnc_rst) begin
        if (dbnc_rst) begin
            state_reg        <= IDLE;
            pi_prev_reg      <= 1'b1;
            bit_cnt_reg      <= '0;
            row_reg          <= '0;
            col_reg          <= '0;
            wdog_reg         <= '0;
            shift_reg        <= '0;
            pix_valid_reg    <= 1'b0;
            pix_hsv_reg      <= '0;
            pix_row_reg      <= '0;
            pix_col_reg      <= '0;
            cls_start_reg    <= 1'b0;
            result_reg       <= 2'b00;
            result_valid_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            bb_reg           <= 3'b111;
            led_lo_reg       <= 4'b0000;
        end else begin
            state_reg        <= state_next;
            pi_prev_reg      <= dbnc_pi_clk;
            bit_cnt_reg      <= bit_cnt_next;
            row_reg          <= row_next;
            col_reg          <= col_next;
            wdog_reg         <= wdog_next;
            shift_reg        <= shift_next;
            pix_valid_reg    <= pix_valid_next;
            pix_hsv_reg      <= pix_hsv_next;
            pix_row_reg      <= pix_row_next;
            pix_col_reg      <= pix_col_next;
            cls_start_reg    <= cls_start_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
            frame_err_reg    <= frame_err_next;
            bb_reg           <= bb_next;
            led_lo_reg       <= led_lo_next;
        end
    end

    assign bus.pix_valid = pix_valid_reg;
    assign bus.pix_hsv   = pix_hsv_reg;
    assign bus.pix_row   = pix_row_reg;
    assign bus.pix_col   = pix_col_reg;
    assign bus.cls_start = cls_start_reg;

    assign busy         = (state_reg != IDLE);
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign frame_err    = frame_err_reg;
    assign breadboard   = bb_reg;
    assign led          = {frame_err_reg, busy, led_lo_reg};

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed-sequence bench with random pixel words; expectations come from a
// frame-position model and a classification display table.
module tb_frame_capture_ctrl;
    localparam int LENGTH     = 16;
    localparam int WIDTH      = 16;
    localparam int PIXEL_BITS = 24;
    localparam int TIMEOUT    = 4096;

    logic       slow_clk    = 1'b0;
    logic       dbnc_rst    = 1'b0;
    logic       dbnc_pi_clk = 1'b1;
    logic       dbnc_bit    = 1'b0;
    logic [1:0] result;
    logic       result_valid;
    logic       busy;
    logic       frame_err;
    logic [2:0] breadboard;
    logic [5:0] led;

    frame_capture_if #(.LENGTH(LENGTH), .WIDTH(WIDTH), .PIXEL_BITS(PIXEL_BITS)) bus ();

    frame_capture_ctrl #(
        .LENGTH(LENGTH), .WIDTH(WIDTH), .PIXEL_BITS(PIXEL_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .slow_clk    (slow_clk),
        .dbnc_rst    (dbnc_rst),
        .dbnc_pi_clk (dbnc_pi_clk),
        .dbnc_bit    (dbnc_bit),
        .bus         (bus),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .frame_err   (frame_err),
        .breadboard  (breadboard),
        .led         (led)
    );

    always #5 slow_clk = ~slow_clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pv_cnt = 0;
    int cs_cnt = 0;
    int cs_cyc = 0;
    int last_edge_cyc = 0;
    int pix_idx = 0;
    logic [23:0] cap_hsv;
    logic [3:0]  cap_row;
    logic [3:0]  cap_col;

    // Display model: what the indicators should show after each classification.
    logic [3:0] led_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [2:0] bb_tab  [4] = '{3'b110, 3'b101, 3'b011, 3'b000};
    logic [1:0] m_res;
    logic       m_rv;
    logic       m_err;
    logic [3:0] m_led_lo;
    logic [2:0] m_bb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_display(input string tag, input logic exp_busy);
        chk({tag, ".result"}, 32'(result), 32'(m_res));
        chk({tag, ".result_valid"}, 32'(result_valid), 32'(m_rv));
        chk({tag, ".breadboard"}, 32'(breadboard), 32'(m_bb));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_err));
        chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
        chk({tag, ".led"}, 32'(led), 32'({m_err, exp_busy, m_led_lo}));
    endtask

    task automatic model_reset();
        m_res = 2'b00; m_rv = 1'b0; m_err = 1'b0; m_led_lo = 4'b0000; m_bb = 3'b111;
    endtask

    task automatic tick();
        @(posedge slow_clk);
        #1;
        cyc++;
        if (bus.pix_valid === 1'b1) begin
            pv_cnt++;
            cap_hsv = bus.pix_hsv;
            cap_row = bus.pix_row;
            cap_col = bus.pix_col;
        end
        if (bus.cls_start === 1'b1) begin
            cs_cnt++;
            cs_cyc = cyc;
        end
    endtask

    task automatic send_bit(input logic b, input int hi, input int lo);
        dbnc_bit    = b;
        dbnc_pi_clk = 1'b1;
        tick();
        last_edge_cyc = cyc;
        repeat (hi - 1) tick();
        dbnc_pi_clk = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic send_word(input logic [23:0] w, input int hi, input int lo);
        pv_cnt = 0;
        for (int i = 0; i < PIXEL_BITS; i++) send_bit(w[i], hi, lo);
        chk($sformatf("pix_valid_count[%0d]", pix_idx), 32'(pv_cnt), 32'd1);
        chk($sformatf("pix_hsv[%0d]", pix_idx), 32'(cap_hsv), 32'(w));
        chk($sformatf("pix_row[%0d]", pix_idx), 32'(cap_row), 32'(pix_idx / WIDTH));
        chk($sformatf("pix_col[%0d]", pix_idx), 32'(cap_col), 32'(pix_idx % WIDTH));
        chk($sformatf("busy_after_pix[%0d]", pix_idx), 32'(busy), 32'd1);
        pix_idx++;
    endtask

    task automatic send_frame(input bit fixed_first);
        logic [23:0] w;
        pix_idx = 0;
        cs_cnt  = 0;
        for (int p = 0; p < LENGTH * WIDTH; p++) begin
            if (p == 0 && fixed_first) begin
                send_word(24'h50FF1E, 2, 2);
            end else begin
                w = 24'($urandom);
                send_word(w, 1, 1);
            end
        end
        chk("cls_start_count", 32'(cs_cnt), 32'd1);
        chk("busy_wait_cls", 32'(busy), 32'd1);
    endtask

    task automatic classify(input logic [1:0] code, input int delay);
        while (cyc < cs_cyc + delay) tick();
        bus.cls_done   = 1'b1;
        bus.cls_result = code;
        tick();
        bus.cls_done   = 1'b0;
        bus.cls_result = 2'($urandom);
        m_res    = code;
        m_rv     = 1'b1;
        m_led_lo = led_tab[code];
        m_bb     = bb_tab[code];
        check_display($sformatf("classify_%0d", code), 1'b0);
        chk("cls_start_single", 32'(cs_cnt), 32'd1);
    endtask

    task automatic check_bus_reset(input string tag);
        chk({tag, ".pix_valid"}, 32'(bus.pix_valid), 32'd0);
        chk({tag, ".pix_hsv"}, 32'(bus.pix_hsv), 32'd0);
        chk({tag, ".pix_row"}, 32'(bus.pix_row), 32'd0);
        chk({tag, ".pix_col"}, 32'(bus.pix_col), 32'd0);
        chk({tag, ".cls_start"}, 32'(bus.cls_start), 32'd0);
    endtask

    initial begin
        bus.cls_done   = 1'b0;
        bus.cls_result = 2'b00;
        model_reset();

        // Asynchronous reset with the Pi clock held high.
        #2 dbnc_rst = 1'b1;
        #1;
        check_bus_reset("reset");
        check_display("reset", 1'b0);
        repeat (2) @(posedge slow_clk);
        #1 dbnc_rst = 1'b0;
        pv_cnt = 0;
        repeat (10) tick();
        chk("hold_high_no_strobe", 32'(pv_cnt), 32'd0);
        check_display("hold_high", 1'b0);
        dbnc_pi_clk = 1'b0;
        tick();

        // Frame 1: known first word at one edge per 4 cycles, then classify scissors.
        send_frame(1'b1);
        classify(2'b10, 3);

        // Partial frame then silence: watchdog abort leaves the display alone.
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 1, 1);
        chk("busy_partial", 32'(busy), 32'd1);
        while (cyc < last_edge_cyc + TIMEOUT - 2) tick();
        chk("busy_before_recv_timeout", 32'(busy), 32'd1);
        while (cyc < last_edge_cyc + TIMEOUT + 1) tick();
        m_err = 1'b1;
        check_display("recv_timeout", 1'b0);

        // Frame 2: cls_done held during the cls_start cycle must be ignored.
        bus.cls_done   = 1'b1;
        bus.cls_result = 2'b00;
        send_frame(1'b0);
        bus.cls_done   = 1'b0;
        check_display("coincident_done_ignored", 1'b1);
        classify(2'b11, 4);

        // Frame 3: classifier never answers.
        send_frame(1'b0);
        while (cyc < cs_cyc + TIMEOUT - 2) tick();
        chk("busy_before_cls_timeout", 32'(busy), 32'd1);
        while (cyc < cs_cyc + TIMEOUT + 1) tick();
        m_rv = 1'b0;
        m_bb = 3'b000;
        check_display("cls_timeout", 1'b0);

        // Reset in the middle of a frame discards everything.
        for (int i = 0; i < 5; i++) send_bit(1'($urandom), 1, 1);
        dbnc_rst = 1'b1;
        #1;
        model_reset();
        check_bus_reset("mid_reset");
        check_display("mid_reset", 1'b0);
        tick();
        dbnc_rst = 1'b0;
        tick();

        // Frame 4: a stray edge while waiting for the classifier flags an error.
        send_frame(1'b0);
        chk("frame_err_before_stray", 32'(frame_err), 32'd0);
        send_bit(1'b1, 1, 1);
        m_err = 1'b1;
        chk("frame_err_stray_edge", 32'(frame_err), 32'd1);
        chk("busy_after_stray_edge", 32'(busy), 32'd1);
        classify(2'b00, 6);

        // Frame 5: paper.
        send_frame(1'b0);
        classify(2'b01, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frame_capture_ctrl.md
Name: frame_capture_ctrl

Overview:
Sequencer between the debounced Raspberry Pi serial link and the hand-mask/classifier datapath. Runs entirely in the slow_clk domain:
- detects Pi clock edges and assembles 24-bit HSV words, LSB first;
- issues one pixel strobe per word with row/column indices;
- starts the classifier after a full frame, then latches and displays the result.

A watchdog drops stalled frames so a lost bit cannot misalign later frames.

Parameters:
LENGTH, 16, image rows
WIDTH, 16, image columns
PIXEL_BITS, 24, bits per HSV word (V[23:16], S[15:8], H[7:0])
TIMEOUT, 4096, slow_clk cycles without progress before abort

Ports:
slow_clk  in  1  clock
dbnc_rst  in  1  reset; asynchronous, active-high
dbnc_pi_clk  in  1  debounced Pi clock level
dbnc_bit  in  1  debounced serial data bit
pix_valid  out  1  one-cycle strobe: pix_hsv/pix_row/pix_col valid
pix_hsv  out  24  assembled HSV word
pix_row  out  $clog2(LENGTH)  row index of strobed pixel
pix_col  out  $clog2(WIDTH)  column index of strobed pixel
cls_start  out  1  one-cycle classifier start pulse
cls_done  in  1  classifier result valid
cls_result  in  2  00 rock, 01 paper, 10 scissors, 11 invalid
result  out  2  latched classification
result_valid  out  1  result holds a completed classification
busy  out  1  high in RECV or WAIT_CLS
frame_err  out  1  sticky error flag; cleared only by reset
breadboard  out  3  active-low indicators
led  out  6  board LEDs

Behaviour:
Reset (async, dbnc_rst=1):
- state IDLE; bit_cnt, row, col and watchdog = 0; pi_prev = 1, so a Pi clock high at release is not counted as an edge.
- pix_valid=0, pix_hsv=0, pix_row=0, pix_col=0, cls_start=0.
- result=0, result_valid=0, busy=0, frame_err=0, breadboard=3'b111, led=0.
- Reset mid-frame discards all partial data.

Edge detect:
- edge = dbnc_pi_clk & ~pi_prev; pi_prev registers dbnc_pi_clk every cycle.
- On an edge in IDLE/RECV: shift_reg[bit_cnt] <= dbnc_bit, sampled in the edge cycle.

Pixel assembly:
- Edge at cycle N with bit_cnt == PIXEL_BITS-1 completes a word.
- At N+1: pix_valid=1 for exactly one cycle, with pix_hsv = complete word and pix_row/pix_col = current indices.
- Indices then advance: col increments; at col == WIDTH-1, col <= 0 and row++.
- bit_cnt wraps to 0.

States:
- IDLE: first edge -> RECV (that bit is stored).
- RECV: after the strobe of pixel (LENGTH-1, WIDTH-1) -> WAIT_CLS; row/col reset to 0.
- WAIT_CLS: cls_start=1 in the first cycle only. cls_done is sampled from the following cycle onward; a cls_done coincident with cls_start is ignored. On cls_done, latch outputs in the next cycle and go to IDLE.
  - 00: led[2:0]=001, breadboard=110
  - 01: led[2:0]=010, breadboard=101
  - 10: led[2:0]=100, breadboard=011
  - 11: led[2:0]=000, breadboard=000, led[3]=1 (led[3]=0 otherwise)
  - In all cases result=cls_result and result_valid=1.
- led[4]=busy, led[5]=frame_err.
- Edges in WAIT_CLS are ignored and set frame_err.

Display hold:
- result, breadboard and led[3:0] hold until the next classification completes.
- Starting a new frame does not clear them.

Watchdog:
- Counts cycles in RECV since the last edge, and in WAIT_CLS since entry.
- On reaching TIMEOUT-1:
  - RECV: abort frame (bit_cnt/row/col <= 0), frame_err=1, go to IDLE; display unchanged.
  - WAIT_CLS: additionally result_valid=0, breadboard=000.
- Counter is 0 in IDLE. An edge coincident with timeout in RECV: the timeout wins and the bit is dropped.

Test Plan:
- Reset with dbnc_pi_clk held high, release, hold high 10 cycles -> no bit accepted, bit_cnt=0, breadboard=111, led=0.
- Serial 24 bits of 0x50FF1E, LSB first, one edge per 4 cycles -> exactly one pix_valid one cycle after the 24th edge, pix_hsv=0x50FF1E, row=0, col=0, busy=1.
- Full 256-pixel frame, cls_done=1 with cls_result=10 three cycles after cls_start -> single cls_start; result=10, breadboard=011, led=6'b000100 next cycle, state IDLE.
- Pixel 17 delivered -> strobe with row=1, col=1; pixel 16 -> row=1, col=0 (column wrap).
- 10 bits then silence for TIMEOUT cycles -> frame_err=1, led[5]=1, IDLE. A fresh full frame then classifies correctly with pixel 0 at row 0, col 0.
- cls_result=11 -> breadboard=000, led[3]=1, result_valid=1. Separately: cls_done never arrives -> after TIMEOUT, result_valid=0, breadboard=000, frame_err=1.
